// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state type
// and a small sizing helper.
package mdu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DIV_FIX = 2'd3
  } mdu_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider: WIDTH shift/subtract cycles on magnitudes, then a
// combinational sign-fix presented while valid is high.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             abort,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dsr, dvd_orig;
  logic             neg_q, neg_r, div_zero;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, diff;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    neg_a   = is_signed & dividend[WIDTH-1];
    neg_b   = is_signed & divisor[WIDTH-1];
    abs_a   = neg_a ? -dividend : dividend;
    abs_b   = neg_b ? -divisor : divisor;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (abort) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= ITERS;
    end else if (running) begin
      if (cnt != '0) cnt <= cnt - ONE;
      else           running <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; start always loads them before they are read.
  always_ff @(posedge clk) begin
    if (start && !abort) begin
      rem      <= '0;
      quo      <= abs_a;
      dsr      <= abs_b;
      dvd_orig <= dividend;
      neg_q    <= neg_a ^ neg_b;
      neg_r    <= neg_a;
      div_zero <= (divisor == '0);
    end else if (running && cnt != '0) begin
      rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  always_comb begin
    valid = running && (cnt == '0);
    if (div_zero) begin
      quotient  = '1;
      remainder = dvd_orig;
    end else begin
      quotient  = neg_q ? -quo : quo;
      remainder = neg_r ? -rem : rem;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// MIPS-style multiply/divide unit with HI/LO registers, busy stall and flush.
// The divider is built in only when MDU_DIV_EN is defined.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W   = $clog2(max_int(WIDTH, MULT_LAT) + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  mdu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept, accept_mul, accept_div, abort;
  logic               mul_commit, div_commit, mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, product, prod_q;

  // Sign/zero-extend to 2*WIDTH so one multiplier serves MULT and MULTU.
  assign mul_signed = (op == OP_MULT);
  assign ext_a      = {{WIDTH{mul_signed & src_a[WIDTH-1]}}, src_a};
  assign ext_b      = {{WIDTH{mul_signed & src_b[WIDTH-1]}}, src_b};
  assign product    = ext_a * ext_b;
  assign accept_mul = accept && (op == OP_MULT || op == OP_MULTU);

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] div_q, div_r;
  logic             div_valid;

  assign accept_div = accept && (op == OP_DIV || op == OP_DIVU);

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept_div),
    .dividend (src_a),
    .divisor  (src_b),
    .is_signed(op == OP_DIV),
    .abort    (abort),
    .quotient (div_q),
    .remainder(div_r),
    .valid    (div_valid)
  );
`else
  assign accept_div = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_mul)      state_nxt = MUL_RUN;
        else if (accept_div) state_nxt = DIV_RUN;
      end
      MUL_RUN: if (flush || cnt == ONE) state_nxt = IDLE;
      DIV_RUN: begin
        if (flush)           state_nxt = IDLE;
        else if (cnt == ONE) state_nxt = DIV_FIX;
      end
      DIV_FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flush on the commit edge wins, so both commits are gated by !flush.
  always_comb begin
    busy       = (state != IDLE);
    accept     = (state == IDLE) && start && !flush;
    abort      = busy && flush;
    mul_commit = (state == MUL_RUN) && (cnt == ONE) && !flush;
    div_commit = 1'b0;
`ifdef MDU_DIV_EN
    div_commit = (state == DIV_FIX) && div_valid && !flush;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= mul_commit | div_commit;

      if (accept_mul)      cnt <= MUL_CNT;
      else if (accept_div) cnt <= DIV_CNT;
      else if (abort)      cnt <= '0;
      else if (cnt != '0)  cnt <= cnt - ONE;

      if (accept && op == OP_MTHI) hi <= src_a;
      if (accept && op == OP_MTLO) lo <= src_a;
      if (mul_commit) {hi, lo} <= prod_q;
`ifdef MDU_DIV_EN
      if (div_commit) begin
        hi <= div_r;
        lo <= div_q;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept_mul) prod_q <= product;
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width and HI/LO width; legal range 8..64.
REQ-002 SHALL have parameter MULT_LAT, default 5: busy cycles per multiply; legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: issue strobe, sampled on the rising edge of clk.
REQ-006 SHALL have port op, input, 3 bits: operation code, encoded as in mdu_pkg.
REQ-007 SHALL have port src_a, input, WIDTH bits: multiplicand, dividend, or MTHI/MTLO data.
REQ-008 SHALL have port src_b, input, WIDTH bits: multiplier or divisor.
REQ-009 SHALL have port flush, input, 1 bit: aborts the operation in flight.
REQ-010 SHALL have port busy, output, 1 bit: operation in flight; drives the pipeline stall.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a result is committed.
REQ-012 SHALL have port hi, output, WIDTH bits: architectural HI register.
REQ-013 SHALL have port lo, output, WIDTH bits: architectural LO register.

Function
REQ-014 SHALL support ops MULT, MULTU, DIV, DIVU, MTHI, MTLO; any other code SHALL be ignored (no state change).
REQ-015 SHALL accept start only when busy=0 and flush=0; start while busy or with flush=1 SHALL be dropped.
REQ-016 SHALL commit MTHI/MTLO on the accepting edge (src_a to hi or lo); busy stays 0, done stays 0.
REQ-017 SHALL, on accepted MULT/MULTU, drive busy=1 for exactly MULT_LAT cycles starting the cycle after acceptance.
REQ-018 SHALL commit the 2*WIDTH product on the edge where busy falls: {hi,lo}=product; signed for MULT, unsigned for MULTU.
REQ-019 SHALL, on accepted DIV/DIVU, drive busy=1 for exactly WIDTH+1 cycles: WIDTH restoring iterations plus one sign-fix cycle.
REQ-020 SHALL commit lo=quotient and hi=remainder for division; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-021 SHALL, for divide by zero, commit hi=src_a and lo=all ones, with unchanged latency.
REQ-022 SHALL, for signed DIV of most-negative by -1, commit lo=most-negative and hi=0.
REQ-023 SHALL pulse done=1 for the single cycle after each multiply/divide commit edge.
REQ-024 SHALL hold hi/lo at their previous values throughout busy; partial results are never visible.
REQ-025 SHALL capture operands at acceptance; src_a/src_b changes during busy have no effect.
REQ-026 SHALL, on flush=1 while busy, clear busy at the next edge, discard the result, leave hi/lo unchanged, and suppress done.
REQ-027 SHALL let flush on the same edge as the commit edge win: no commit, no done.
REQ-028 SHALL implement a state machine IDLE -> MUL_RUN or DIV_RUN -> (DIV_FIX, divide only) -> IDLE.
REQ-029 SHALL return every state to IDLE on flush.

Reset
REQ-030 SHALL, on reset=0, asynchronously force IDLE, busy=0, done=0, hi=0, lo=0, and clear all counters.
REQ-031 SHALL, on reset asserted mid-operation, discard the operation; the first start after release behaves as from power-up.

Configuration
REQ-032 SHALL compile the divider in only when macro MDU_DIV_EN is defined.
REQ-033 SHALL, without MDU_DIV_EN, treat DIV/DIVU as ignored ops: no busy, no done, hi/lo unchanged, and instantiate no divider logic.

Structure
REQ-034 SHALL place the op encoding constants and the state enumeration typedef in shared package mdu_pkg.
REQ-035 SHALL implement the iterative divider as sub-module mdu_divider (start, operands, signed flag, abort; quotient, remainder, valid).
REQ-036 SHALL implement the multiplier as a single-cycle product captured at acceptance, delayed by a MULT_LAT down-counter.

Verification (WIDTH=32, MULT_LAT=5, MDU_DIV_EN defined)
REQ-037 MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle.
REQ-038 DIV src_a=-7, src_b=2 -> busy 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi=7, lo=0xFFFFFFFF.
REQ-039 MULTU 0xFFFFFFFF*0xFFFFFFFF, flush at busy cycle 3 -> busy falls next edge, hi/lo keep prior values, no done.
REQ-040 start MTHI 0x1234 while a divide is busy -> dropped, hi unchanged; MTLO 0xABCD when idle -> lo=0xABCD on that edge, busy=0.
REQ-041 reset=0 asserted mid-DIV -> outputs 0 immediately; after release, MULT 6*7 -> lo=42, hi=0 after 5 cycles.
REQ-042 Rebuild without MDU_DIV_EN and issue DIV 10/2 -> busy stays 0, no done, hi/lo unchanged.
